// File: rtl/wb_byte_stream_fifo.sv
// wb_byte_stream_fifo: 8-bit Wishbone slave bridging byte TX/RX FIFOs to valid/ready streams.
// Define WB_BYTE_STREAM_FIFO_IRQ_EN to add irq_o and the STATUS[7:5] interrupt enables.
module wb_byte_stream_fifo #(
  parameter int aw         = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [aw-1:0] wbs_adr_i,
  input  logic [7:0]    wbs_dat_i,
  input  logic          wbs_we_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic [2:0]    wbs_cti_i,
  input  logic [1:0]    wbs_bte_i,
  output logic [7:0]    wbs_dat_o,
  output logic          wbs_ack_o,
  output logic          wbs_err_o,
  output logic          wbs_stall_o,
  output logic          wbs_rty_o,
`ifdef WB_BYTE_STREAM_FIFO_IRQ_EN
  output logic          irq_o,
`endif
  output logic [7:0]    tx_data_o,
  output logic          tx_valid_o,
  input  logic          tx_ready_i,
  input  logic [7:0]    rx_data_i,
  input  logic          rx_valid_i,
  output logic          rx_ready_o
);
  localparam int depth = 1 << DEPTH_LOG2;
  localparam int cw    = DEPTH_LOG2 + 1;
  logic [7:0] tx_mem [depth];
  logic [7:0] rx_mem [depth];
  logic [DEPTH_LOG2-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [cw-1:0] tx_cnt, rx_cnt;
  logic rx_ovr, tx_empty, tx_full, rx_empty, rx_full;
  logic accept, sel_data, sel_stat, bad, tx_push, tx_pop, rx_push, rx_pop, w1c;
  logic [1:0] a;
  logic [2:0] ien;
  logic [7:0] status, rd_val;
  logic unused;
  assign unused = ^{wbs_cti_i, wbs_bte_i, wbs_adr_i[aw-1:2]};
  assign a        = wbs_adr_i[1:0];
  assign tx_empty = tx_cnt == '0;
  assign tx_full  = tx_cnt[DEPTH_LOG2];
  assign rx_empty = rx_cnt == '0;
  assign rx_full  = rx_cnt[DEPTH_LOG2];
  assign accept   = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & ~wbs_err_o;
  assign sel_data = a == 2'd0;
  assign sel_stat = a == 2'd1;
  // flags are the registered state, so a same-cycle stream transfer never rescues an access
  assign bad      = accept & sel_data & (wbs_we_i ? tx_full : rx_empty);
  assign tx_push  = accept & wbs_we_i & sel_data & ~tx_full;
  assign rx_pop   = accept & ~wbs_we_i & sel_data & ~rx_empty;
  assign tx_pop   = tx_valid_o & tx_ready_i;
  assign rx_push  = rx_valid_i & rx_ready_o;
  assign w1c      = accept & wbs_we_i & sel_stat & wbs_dat_i[4];
  assign status   = {ien, rx_ovr, rx_full, rx_empty, tx_full, tx_empty};
  assign rd_val   = a == 2'd0 ? rx_mem[rx_rp] :
                    a == 2'd1 ? status :
                    a == 2'd2 ? 8'(tx_cnt) : 8'(rx_cnt);
  assign tx_valid_o  = ~tx_empty;
  assign tx_data_o   = tx_mem[tx_rp];
  assign rx_ready_o  = ~rx_full & ~wb_rst_i;
  assign wbs_stall_o = wbs_stb_i & (wbs_ack_o | wbs_err_o);
  assign wbs_rty_o   = 1'b0;
  always_ff @(posedge wb_clk_i) begin
    if (tx_push) tx_mem[tx_wp] <= wbs_dat_i;
    if (rx_push) rx_mem[rx_wp] <= rx_data_i;
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      wbs_dat_o <= '0;
      tx_wp     <= '0;
      tx_rp     <= '0;
      rx_wp     <= '0;
      rx_rp     <= '0;
      tx_cnt    <= '0;
      rx_cnt    <= '0;
      rx_ovr    <= 1'b0;
    end else begin
      wbs_ack_o <= accept & ~bad;
      wbs_err_o <= bad;
      wbs_dat_o <= (accept & ~bad & ~wbs_we_i) ? rd_val : '0;
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop) tx_rp <= tx_rp + 1'b1;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop) rx_rp <= rx_rp + 1'b1;
      tx_cnt    <= tx_cnt + cw'(tx_push) - cw'(tx_pop);
      rx_cnt    <= rx_cnt + cw'(rx_push) - cw'(rx_pop);
      rx_ovr    <= (rx_ovr & ~w1c) | (rx_valid_i & rx_full);
    end
  end
`ifdef WB_BYTE_STREAM_FIFO_IRQ_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ien   <= '0;
      irq_o <= 1'b0;
    end else begin
      if (accept & wbs_we_i & sel_stat) ien <= wbs_dat_i[7:5];
      irq_o <= |(ien & {rx_ovr, tx_empty, ~rx_empty});
    end
  end
`else
  assign ien = '0;
`endif
endmodule

// File: tb/tb_wb_byte_stream_fifo.sv
// tb_wb_byte_stream_fifo: randomized bench against a queue-based model of the byte FIFO slave.
module tb_wb_byte_stream_fifo;
  localparam int D = 16;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, cyc, stb, we, ack, err, stall, rty, tx_valid, tx_ready, rx_valid, rx_ready;
  logic [31:0] adr;
  logic [7:0] dat_i, dat_o, tx_data, rx_data;
  logic [2:0] cti;
  logic [1:0] bte;
  logic irq;
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  bit m_ack, m_err, m_ovr, m_irq;
  logic [7:0] m_dat;
  logic [2:0] m_ien;
  int n_chk, n_fail;

  wb_byte_stream_fifo dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_we_i(we),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_cti_i(cti), .wbs_bte_i(bte), .wbs_dat_o(dat_o),
    .wbs_ack_o(ack), .wbs_err_o(err), .wbs_stall_o(stall), .wbs_rty_o(rty),
`ifdef WB_BYTE_STREAM_FIFO_IRQ_EN
    .irq_o(irq),
`endif
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready)
  );
`ifndef WB_BYTE_STREAM_FIFO_IRQ_EN
  assign irq = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit c, input bit s, input bit w, input logic [1:0] a,
                       input logic [7:0] d, input bit txr, input bit rxv, input logic [7:0] rxd);
    logic [7:0] st, rv;
    bit acc, full_t, empty_r, full_r;
    rst = r; cyc = c; stb = s; we = w; dat_i = d;
    adr = ($urandom() & 32'hFFFF_FFFC) | 32'(a);
    cti = 3'($urandom()); bte = 2'($urandom());
    tx_ready = txr; rx_valid = rxv; rx_data = rxd;
    #1;
    check("stall", stall, s && (m_ack || m_err));
    check("rx_ready", rx_ready, !r && rxq.size() < D);
    check("tx_valid", tx_valid, txq.size() > 0);
    if (txq.size() > 0) check("tx_data", tx_data, txq[0]);
    check("ack", ack, m_ack);
    check("err", err, m_err);
    check("dat_o", dat_o, m_dat);
    check("rty", rty, 0);
`ifdef WB_BYTE_STREAM_FIFO_IRQ_EN
    check("irq", irq, m_irq);
`endif
    if (r) begin
      txq.delete(); rxq.delete();
      m_ack = 0; m_err = 0; m_dat = 0; m_ovr = 0; m_ien = 0; m_irq = 0;
    end else begin
      full_t  = txq.size() == D;
      empty_r = rxq.size() == 0;
      full_r  = rxq.size() == D;
      st = {m_ien, m_ovr, full_r, empty_r, full_t, txq.size() == 0};
      m_irq = (m_ien[0] && !empty_r) || (m_ien[1] && txq.size() == 0) || (m_ien[2] && m_ovr);
      acc = c && s && !m_ack && !m_err;
      rv = a == 0 ? (empty_r ? 8'h0 : rxq[0]) : a == 1 ? st :
           a == 2 ? 8'(txq.size()) : 8'(rxq.size());
      m_err = acc && a == 0 && (w ? full_t : empty_r);
      m_ack = acc && !m_err;
      m_dat = (m_ack && !w) ? rv : 8'h0;
      if (txr && txq.size() > 0) void'(txq.pop_front());
      if (m_ack && w && a == 0) txq.push_back(d);
      if (m_ack && !w && a == 0) void'(rxq.pop_front());
      if (m_ack && w && a == 1) begin
        if (d[4]) m_ovr = 0;
`ifdef WB_BYTE_STREAM_FIFO_IRQ_EN
        m_ien = d[7:5];
`endif
      end
      if (rxv) begin
        if (!full_r) rxq.push_back(rxd);
        else m_ovr = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit txr);
    cycle(0, 0, 0, 0, 0, 0, txr, 0, 0);
  endtask

  initial begin
    int txr_p[4] = '{5, 90, 50, 20};
    int rxv_p[4] = '{80, 10, 50, 95};
    bit s, w;
    logic [1:0] a;
    logic [7:0] d;
    n_chk = 0; n_fail = 0;
    rst = 1; cyc = 0; stb = 0; we = 0; adr = 0; dat_i = 0; cti = 0; bte = 0;
    tx_ready = 0; rx_valid = 0; rx_data = 0;
    repeat (2) @(negedge clk);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 1, 0, 0, 0, 0);
    idle(0);
    cycle(0, 1, 1, 0, 2, 0, 0, 0, 0);
    idle(0);
    cycle(0, 1, 1, 0, 3, 0, 0, 0, 0);
    idle(0);
    for (int i = 0; i < 17; i++) begin
      cycle(0, 1, 1, 1, 0, 8'hA1 + 8'(i), 0, 0, 0);
      idle(0);
    end
    cycle(0, 1, 1, 0, 2, 0, 0, 0, 0);
    idle(0);
    repeat (18) idle(1);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 8'h3C);
    cycle(0, 1, 1, 0, 0, 0, 0, 0, 0);
    idle(0);
    cycle(0, 1, 1, 0, 0, 0, 0, 0, 0);
    idle(0);
    for (int i = 0; i < 17; i++) cycle(0, 0, 0, 0, 0, 0, 0, 1, 8'(i * 7));
    cycle(0, 1, 1, 0, 1, 0, 0, 0, 0);
    idle(0);
    cycle(0, 1, 1, 1, 1, 8'h10, 0, 0, 0);
    idle(0);
    cycle(0, 1, 1, 0, 1, 0, 0, 0, 0);
    idle(0);
    for (int i = 0; i < 8; i++) cycle(0, 1, 1, 1, 0, 8'h50 + 8'(i), 0, 0, 0);
    cycle(1, 1, 1, 1, 0, 8'hEE, 0, 1, 8'h11);
    s = 0; w = 0; a = 0; d = 0;
    for (int p = 0; p < 8; p++) begin
      for (int k = 0; k < 400; k++) begin
        if (!s || $urandom_range(2) == 0) begin
          a = $urandom_range(99) < 60 ? 2'd0 : 2'($urandom());
          w = $urandom_range(1) == 1;
          d = 8'($urandom());
        end
        s = $urandom_range(99) < 60;
        cycle(0, s, s, w, a, d, $urandom_range(99) < txr_p[p % 4],
              $urandom_range(99) < rxv_p[p % 4], 8'($urandom()));
      end
      if (p == 3) cycle(1, 1, 1, 1, 1, 8'hFF, 1, 1, 8'h22);
    end
    repeat (3) idle(0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
